// File: rtl/sdp_one_clk_ram.sv
// rtl/sdp_one_clk_ram.sv - single-clock simple dual-port RAM, registered read, optional 2nd output stage (SDP_OUT_REG_EN)
module sdp_one_clk_ram #(
  parameter int    AW                    = 4,
  parameter int    DW                    = 4,
  parameter string RW_ADDR_COLLISION_VAL = "yes"
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] din,
  input  logic          ren,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] dout
);

  localparam int DEPTH       = 1 << AW;
  localparam bit WRITE_FIRST = (RW_ADDR_COLLISION_VAL == "yes");

  // Only "yes" and "no" describe a defined read-during-write behaviour.
  generate
    if (RW_ADDR_COLLISION_VAL != "yes" && RW_ADDR_COLLISION_VAL != "no") begin : g_cfg_err
      $error("sdp_one_clk_ram: RW_ADDR_COLLISION_VAL must be \"yes\" or \"no\"");
    end
  endgenerate

  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] rd_data_d, rd_data_q;
  logic          collide;

  // Storage has no reset so contents survive rst_n; writes are blocked while rst_n is low.
  always_ff @(posedge clk) begin
    if (rst_n && wen) begin
      mem[waddr] <= din;
    end
  end

  // First read stage: hold when ren=0, bypass din on a collision in write-first mode.
  always_comb begin
    rd_data_d = rd_data_q;
    collide   = wen && ren && (waddr == raddr);
    if (ren) begin
      if (WRITE_FIRST && collide) begin
        rd_data_d = din;
      end else begin
        rd_data_d = mem[raddr];
      end
    end
  end

  // First read stage register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

`ifdef SDP_OUT_REG_EN
  logic          ren_dly_d, ren_dly_q;
  logic [DW-1:0] out_data_d, out_data_q;

  // Second stage follows the first one cycle behind, advancing only after a read.
  always_comb begin
    ren_dly_d  = ren;
    out_data_d = out_data_q;
    if (ren_dly_q) begin
      out_data_d = rd_data_q;
    end
  end

  // Second stage registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ren_dly_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      ren_dly_q  <= ren_dly_d;
      out_data_q <= out_data_d;
    end
  end

  assign dout = out_data_q;
`else
  assign dout = rd_data_q;
`endif

endmodule

// File: tb/tb_sdp_one_clk_ram.sv
// tb/tb_sdp_one_clk_ram.sv - scoreboard bench for sdp_one_clk_ram (AW=4, DW=4)
module tb_sdp_one_clk_ram;

  localparam int    AW   = 4;
  localparam int    DW   = 4;
  localparam string COLL = "yes";
`ifdef SDP_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wen = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] din = '0;
  logic          ren = 1'b0;
  logic [AW-1:0] raddr = '0;
  logic [DW-1:0] dout;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] model [0:15];

  sdp_one_clk_ram #(
    .AW(AW),
    .DW(DW),
    .RW_ADDR_COLLISION_VAL(COLL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wen(wen),
    .waddr(waddr),
    .din(din),
    .ren(ren),
    .raddr(raddr),
    .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: dout=%h expected=%h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus, driven right after a negedge; a read pushes its expected word.
  task automatic step(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] d,
                      input logic r, input logic [AW-1:0] ra, input logic [DW-1:0] e);
    wen = w; waddr = wa; din = d;
    ren = r; raddr = ra;
    if (r) exp_q.push_back(e);
    if (w) model[wa] = d;
    @(negedge clk);
  endtask

  task automatic idle(input logic [AW-1:0] ra);
    step(1'b0, '0, '0, 1'b0, ra, '0);
  endtask

  // Monitor: tracks read latency itself and checks dout every cycle (new word or hold).
  initial begin : monitor
    logic [1:0]    pipe;
    logic [DW-1:0] last_exp;
    pipe = '0;
    last_exp = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pipe = '0;
        last_exp = '0;
      end else begin
        pipe = {pipe[0], ren};
        if (pipe[LAT-1]) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_underflow: dout=%h expected=<none>", dout);
          end else begin
            last_exp = exp_q.pop_front();
          end
        end
      end
      check("dout_monitor", dout, last_exp);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [DW-1:0] e;
    logic [DW-1:0] d;
    logic [AW-1:0] ra;

    #1;
    check("reset_dout", dout, 4'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: write then read
    step(1'b1, 4'd3, 4'hA, 1'b0, 4'd0, 4'h0);
    step(1'b0, 4'd0, 4'h0, 1'b1, 4'd3, 4'hA);

    // 2: collision
    step(1'b1, 4'd2, 4'h9, 1'b0, 4'd0, 4'h0);
    step(1'b1, 4'd2, 4'h5, 1'b1, 4'd2, (COLL == "yes") ? 4'h5 : 4'h9);
    step(1'b0, 4'd0, 4'h0, 1'b1, 4'd2, 4'h5);

    // 3: preload 0/1, then write 0..7 while reading 0..3 cyclically
    step(1'b1, 4'd0, 4'h1, 1'b0, 4'd0, 4'h0);
    step(1'b1, 4'd1, 4'h2, 1'b0, 4'd0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      d  = 4'hF - 4'(i);
      ra = 4'(i % 4);
      if (ra == 4'(i) && COLL == "yes") e = d;
      else e = model[ra];
      step(1'b1, 4'(i), d, 1'b1, ra, e);
    end

    // 4: ren low with raddr changing -> hold
    idle(4'd9);
    idle(4'd0);
    idle(4'd6);

    // 5: asynchronous reset between edges, memory survives, writes ignored in reset
    step(1'b1, 4'd1, 4'h7, 1'b0, 4'd0, 4'h0);
    step(1'b0, 4'd0, 4'h0, 1'b1, 4'd1, 4'h7);
    idle(4'd0);
    idle(4'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_dout", dout, 4'h0);
    wen = 1'b1; waddr = 4'd1; din = 4'hF;
    ren = 1'b1; raddr = 4'd1;
    @(negedge clk);
    @(negedge clk);
    wen = 1'b0; ren = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_dout", dout, 4'h0);
    step(1'b0, 4'd0, 4'h0, 1'b1, 4'd1, 4'h7);

    // 6: simultaneous write/read at different addresses
    step(1'b1, 4'd4, 4'h6, 1'b1, 4'd5, 4'hA);
    step(1'b0, 4'd0, 4'h0, 1'b1, 4'd4, 4'h6);
    step(1'b0, 4'd0, 4'h0, 1'b1, 4'd3, 4'hC);

    idle(4'd2);
    idle(4'd7);
    idle(4'd1);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: remaining=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
